// File: rtl/qostbc_enc.sv
// Quasi-orthogonal space-time block encoder: one 8-bit QPSK group in, four time slots of four antenna lanes out.
// Optional macro QOSTBC_ENC_B2B_EN lets a new group load while slot 3 is handed off, so blocks run back to back.
module qostbc_enc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_sym,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_r,
    output logic [63:0] out_i,
    output logic [1:0]  out_slot,
    output logic        out_last
);
    // state | meaning
    // IDLE  | waiting for a symbol group, in_ready high
    // EMIT  | presenting slot rows 0..3, out_valid high
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state, state_d;
    logic [1:0]   slot, slot_d;
    logic [7:0]   sym, sym_d;
    logic         rdy_en;
    logic         accept, advance, load;
    logic [7:0]   row_sym;
    logic [1:0]   row_slot;
    logic [127:0] row;

    function automatic logic [15:0] qmap(input logic b);
        return b ? 16'hFF80 : 16'h0080;
    endfunction

    function automatic logic [15:0] neg(input logic [15:0] x);
        return ~x + 16'd1;
    endfunction

    // Returns {real lanes ant0..3, imag lanes ant0..3} for slot t.
    function automatic logic [127:0] slot_row(input logic [7:0] s, input logic [1:0] t);
        logic [15:0] r1, r2, r3, r4, i1, i2, i3, i4;
        r1 = qmap(s[0]); i1 = qmap(s[1]);
        r2 = qmap(s[2]); i2 = qmap(s[3]);
        r3 = qmap(s[4]); i3 = qmap(s[5]);
        r4 = qmap(s[6]); i4 = qmap(s[7]);
        case (t)
            2'd0:    return {r1, r2, r3, r4, i1, i2, i3, i4};
            2'd1:    return {neg(r2), r1, neg(r4), r3, i2, neg(i1), i4, neg(i3)};
            2'd2:    return {neg(r3), neg(r4), r1, r2, i3, i4, neg(i1), neg(i2)};
            default: return {r4, neg(r3), neg(r2), r1, i4, neg(i3), neg(i2), i1};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            slot   <= 2'd0;
            sym    <= 8'd0;
            rdy_en <= 1'b0;
            out_r  <= 64'd0;
            out_i  <= 64'd0;
        end else begin
            state  <= state_d;
            slot   <= slot_d;
            sym    <= sym_d;
            rdy_en <= 1'b1;
            if (load) begin
                out_r <= row[127:64];
                out_i <= row[63:0];
            end
        end
    end

    always_comb begin
        state_d   = state;
        slot_d    = slot;
        sym_d     = sym;
        load      = 1'b0;
        row_sym   = sym;
        row_slot  = slot + 2'd1;
        out_valid = (state == EMIT);
        out_slot  = slot;
        out_last  = (state == EMIT) && (slot == 2'd3);
`ifdef QOSTBC_ENC_B2B_EN
        in_ready  = rdy_en && ((state == IDLE) || (slot == 2'd3 && out_ready));
`else
        in_ready  = rdy_en && (state == IDLE);
`endif
        accept    = in_valid && in_ready;
        advance   = out_valid && out_ready;

        if (accept) begin
            state_d  = EMIT;
            slot_d   = 2'd0;
            sym_d    = in_sym;
            row_sym  = in_sym;
            row_slot = 2'd0;
            load     = 1'b1;
        end else if (advance) begin
            if (slot == 2'd3) begin
                state_d = IDLE;
                slot_d  = 2'd0;
            end else begin
                slot_d = slot + 2'd1;
                load   = 1'b1;
            end
        end
        row = slot_row(row_sym, row_slot);
    end
endmodule

// File: tb/tb_qostbc_enc.sv
// Self-checking bench for qostbc_enc: directed vector table, stall/reset/back-to-back sequences, random blocks vs model.
module tb_qostbc_enc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0]  in_sym;
    logic [63:0] out_r, out_i;
    logic [1:0]  out_slot;

    int n_assert = 0;
    int n_fail   = 0;

    qostbc_enc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
        .out_slot(out_slot), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Antenna a in slot t carries sign * (conj?) s(SRC+1).
    localparam int SRC [4][4] = '{'{0,1,2,3}, '{1,0,3,2}, '{2,3,0,1}, '{3,2,1,0}};
    localparam int SGN [4][4] = '{'{1,1,1,1}, '{-1,1,-1,1}, '{-1,-1,1,1}, '{1,-1,-1,1}};
    localparam int CNJ [4]    = '{1, -1, -1, 1};

    function automatic void model(input logic [7:0] s, input int t,
                                  output logic [63:0] r, output logic [63:0] i);
        int re, im;
        r = '0; i = '0;
        for (int a = 0; a < 4; a++) begin
            re = s[2*SRC[t][a]]     ? -128 : 128;
            im = s[2*SRC[t][a] + 1] ? -128 : 128;
            im = im * CNJ[t];
            re = re * SGN[t][a];
            im = im * SGN[t][a];
            r[63-16*a -: 16] = 16'(re);
            i[63-16*a -: 16] = 16'(im);
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int w = 0;
        while (!in_ready && w < 50) begin
            tick;
            w++;
        end
        chk("ready_wait", in_ready, 1);
    endtask

    logic [63:0] cap_r [4];
    logic [63:0] cap_i [4];
    logic        cap_last [4];

    task automatic run_block(input logic [7:0] s);
        wait_ready;
        in_valid = 1'b1; in_sym = s;
        tick;
        in_valid = 1'b0; in_sym = 8'($urandom);
        chk("latency_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            chk("blk_valid", out_valid, 1);
            chk("blk_slot", 64'(out_slot), 64'(t));
            cap_r[t] = out_r; cap_i[t] = out_i; cap_last[t] = out_last;
            tick;
        end
        out_ready = 1'b0;
        chk("blk_idle_after", out_valid, 0);
    endtask

    typedef struct {
        logic [7:0]  sym;
        int          slot;
        logic [63:0] r;
        logic [63:0] i;
        logic        last;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [63:0] er, ei, hr, hi;
        logic [7:0]  sa, sb;
        int exp_t, cyc, hs, gaps;
        logic acc, got_b;
        int seq [8];

        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] er, ei, hr, hi;
        logic [7:0]  sa, sb;
        int exp_t, cyc, hs, gaps;
        logic acc, got_b;
        int seq [8];

        vecs[0] = '{8'h00, 0, 64'h0080008000800080, 64'h0080008000800080, 1'b0};
        vecs[1] = '{8'h00, 1, 64'hFF800080FF800080, 64'h0080FF800080FF80, 1'b0};
        vecs[2] = '{8'h00, 2, 64'hFF80FF8000800080, 64'h00800080FF80FF80, 1'b0};
        vecs[3] = '{8'h00, 3, 64'h0080FF80FF800080, 64'h0080FF80FF800080, 1'b1};
        vecs[4] = '{8'hFF, 0, 64'hFF80FF80FF80FF80, 64'hFF80FF80FF80FF80, 1'b0};
        vecs[5] = '{8'hFF, 3, 64'hFF8000800080FF80, 64'hFF8000800080FF80, 1'b1};
        vecs[6] = '{8'h01, 0, 64'hFF80008000800080, 64'h0080008000800080, 1'b0};

        rst = 1'b0; in_valid = 1'b0; in_sym = 8'h00; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_i", out_i, 0);
        chk("rst_out_slot", 64'(out_slot), 0);
        chk("rst_out_last", out_last, 0);
        rst = 1'b1;
        tick;
        chk("post_rst_ready", in_ready, 1);

        for (int v = 0; v < 7; v++) begin
            run_block(vecs[v].sym);
            chk("vec_r", cap_r[vecs[v].slot], vecs[v].r);
            chk("vec_i", cap_i[vecs[v].slot], vecs[v].i);
            chk("vec_last", cap_last[vecs[v].slot], vecs[v].last);
            tick;
        end

        // Stall in slot 1 with in_sym toggling.
        wait_ready;
        sa = 8'h5A;
        in_valid = 1'b1; in_sym = sa;
        tick;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        model(sa, 1, er, ei);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_sym = ~in_sym ^ 8'($urandom);
            tick;
            chk("stall_slot", 64'(out_slot), 1);
            chk("stall_r", out_r, er);
            chk("stall_i", out_i, ei);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 1; t < 4; t++) begin
            model(sa, t, er, ei);
            chk("stall_resume_slot", 64'(out_slot), 64'(t));
            chk("stall_resume_r", out_r, er);
            chk("stall_resume_i", out_i, ei);
            tick;
        end
        out_ready = 1'b0;
        chk("stall_idle", out_valid, 0);

        // Reset during slot 2.
        wait_ready;
        in_valid = 1'b1; in_sym = 8'hC3;
        tick;
        in_valid = 1'b0; out_ready = 1'b1;
        tick; tick;
        chk("pre_rst_slot", 64'(out_slot), 2);
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_r", out_r, 0);
        chk("mid_rst_i", out_i, 0);
        chk("mid_rst_slot", 64'(out_slot), 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_ready", in_ready, 0);
        tick;
        #2 rst = 1'b1;
        tick;
        chk("rel_ready", in_ready, 1);
        chk("rel_valid", out_valid, 0);
        run_block(8'h96);
        for (int t = 0; t < 4; t++) begin
            model(8'h96, t, er, ei);
            chk("after_rst_r", cap_r[t], er);
            chk("after_rst_i", cap_i[t], ei);
        end

        // Random blocks with random backpressure.
        for (int b = 0; b < 20; b++) begin
            sa = 8'($urandom);
            wait_ready;
            in_valid = 1'b1; in_sym = sa;
            tick;
            in_valid = 1'b0;
            exp_t = 0; cyc = 0;
            while (exp_t < 4 && cyc < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                in_sym = 8'($urandom);
                #1;
                model(sa, exp_t, er, ei);
                chk("rnd_valid", out_valid, 1);
                chk("rnd_slot", 64'(out_slot), 64'(exp_t));
                chk("rnd_r", out_r, er);
                chk("rnd_i", out_i, ei);
                chk("rnd_last", out_last, (exp_t == 3));
                if (out_ready) exp_t++;
                tick;
                cyc++;
            end
            chk("rnd_bound", 64'(exp_t), 4);
            out_ready = 1'b0;
        end

        // Two groups offered back to back.
        sa = 8'h3C; sb = 8'hA5;
        wait_ready;
        in_valid = 1'b1; in_sym = sa;
        tick;
        in_sym = sb; out_ready = 1'b1;
        hs = 0; gaps = 0; cyc = 0; got_b = 1'b0;
        while (hs < 8 && cyc < 40) begin
            if (out_valid) begin
                seq[hs] = int'(out_slot);
                model((hs < 4) ? sa : sb, hs % 4, hr, hi);
                chk("b2b_r", out_r, hr);
                chk("b2b_i", out_i, hi);
                hs++;
            end else if (hs > 0) begin
                gaps++;
            end
            acc = in_valid && in_ready;
            tick;
            if (acc) begin
                in_valid = 1'b0;
                got_b = 1'b1;
            end
            cyc++;
        end
        out_ready = 1'b0;
        chk("b2b_count", 64'(hs), 8);
        chk("b2b_second_accepted", got_b, 1);
        for (int k = 0; k < 8; k++) chk("b2b_slot_seq", 64'(seq[k]), 64'(k % 4));
`ifdef QOSTBC_ENC_B2B_EN
        chk("b2b_no_gap", 64'(gaps), 0);
`else
        chk("b2b_gap_present", 64'(gaps >= 1), 1);
`endif
        tick;
        chk("final_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/qostbc_enc.md
QOSTBC_ENC -- requirements
Module: qostbc_enc

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The module SHALL have the port in_valid, input, 1 bit: in_sym holds a valid symbol group.
REQ-004 The module SHALL have the port in_ready, output, 1 bit: the encoder accepts in_sym this cycle.
REQ-005 The module SHALL have the port in_sym, input, 8 bits: four QPSK symbols; symbol s(k+1) = in_sym[2k+1:2k] for k = 0..3.
REQ-006 The module SHALL have the port out_valid, output, 1 bit: out_r, out_i and out_slot are valid.
REQ-007 The module SHALL have the port out_ready, input, 1 bit: the downstream consumes the current slot.
REQ-008 The module SHALL have the port out_r, output, 64 bits: real parts for antennas 0..3, four Q8.8 lanes, antenna 0 in [63:48] and antenna 3 in [15:0].
REQ-009 The module SHALL have the port out_i, output, 64 bits: imaginary parts, packed the same way as out_r.
REQ-010 The module SHALL have the port out_slot, output, 2 bits: time-slot index, 0..3.
REQ-011 The module SHALL have the port out_last, output, 1 bit: high when out_slot is 3 and out_valid is high.

Function
REQ-012 QPSK mapping SHALL be: bit 2k selects the real part of s(k+1), bit 2k+1 selects the imaginary part; a 0 maps to +0.5 (16'h0080) and a 1 maps to -0.5 (16'hFF80).
REQ-013 Negation and conjugation SHALL be 16-bit two's complement; with only ±0.5 values, no saturation is required.
REQ-014 Slot rows SHALL be, listing antennas 0..3:
- t0: s1, s2, s3, s4
- t1: -s2*, s1*, -s4*, s3*
- t2: -s3*, -s4*, s1*, s2*
- t3: s4, -s3, -s2, s1
REQ-015 The FSM SHALL have two states: IDLE and EMIT, with a 2-bit slot counter.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 When in_valid and in_ready are both high in IDLE, the module SHALL register the mapped symbols and go to EMIT with slot 0.
REQ-018 out_valid SHALL rise on the cycle after acceptance, giving a latency of 1 clock.
REQ-019 In EMIT, out_valid SHALL be 1 and out_r, out_i and out_slot SHALL be driven from registers only.
REQ-020 In EMIT, out_r, out_i and out_slot SHALL stay stable while out_ready is 0.
REQ-021 When out_valid and out_ready are both high with slot below 3, the slot counter SHALL increment.
REQ-022 When out_valid and out_ready are both high with slot 3, the FSM SHALL return to IDLE, unless REQ-027 applies.
REQ-023 in_sym SHALL be ignored whenever in_ready is 0, and the stored symbols SHALL be unaffected.

Reset
REQ-024 While rst is 0, the module SHALL force:
- state to IDLE and slot to 0
- out_valid, out_last, out_slot, out_r and out_i to 0
- in_ready to 0
REQ-025 After rst deasserts, in_ready SHALL become 1 from the first clock edge.
REQ-026 A reset asserted during EMIT SHALL abort the block immediately, and no partial slots SHALL be emitted after reset.

Configuration
REQ-027 With QOSTBC_ENC_B2B_EN defined, in_ready SHALL also be 1 in EMIT when slot is 3 and out_ready is 1; an accepted group SHALL then load directly into EMIT slot 0, with out_valid staying continuously high and no bubble.
REQ-028 Without QOSTBC_ENC_B2B_EN, in_ready SHALL be 1 only in IDLE, giving at least one idle cycle between blocks.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- in_sym=8'h00, out_ready=1: t0 gives out_r=out_i=64'h0080008000800080.
- Same block, t1: out_r=64'hFF800080FF800080 and out_i=64'h0080FF800080FF80.
- Same block, t3: out_r=out_i=64'h0080FF80FF800080, out_last=1, then IDLE.
- in_sym=8'hFF: t0 gives out_r=out_i=64'hFF80FF80FF80FF80.
- out_ready held at 0 for 5 cycles in slot 1: outputs stable, slot stays 1, in_ready=0, and a toggling in_sym is ignored.
- rst pulsed low during slot 2: all outputs 0 at once; after release, in_ready=1 and the next block starts at slot 0.
- With QOSTBC_ENC_B2B_EN and two groups offered back to back: 8 consecutive out_valid cycles, slot sequence 0,1,2,3,0,1,2,3.
- Without QOSTBC_ENC_B2B_EN, same stimulus: at least one out_valid=0 gap between the two blocks.
